// File: rtl/tx_pcs_encoder_if.sv
// XGMII-side word bus and 66-bit block output of the clause 49 TX encoder.
// The MAC/gearbox side drives words; the encoder returns blocks.
interface tx_pcs_encoder_if;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        i_tx_en;
    logic        phy_tx_ready;
    logic [1:0]  o_header;
    logic [63:0] o_data;
    logic        o_valid;

    modport master (
        output xgmii_txd,
        output xgmii_txc,
        output i_tx_en,
        input  phy_tx_ready,
        input  o_header,
        input  o_data,
        input  o_valid
    );

    modport slave (
        input  xgmii_txd,
        input  xgmii_txc,
        input  i_tx_en,
        output phy_tx_ready,
        output o_header,
        output o_data,
        output o_valid
    );
endinterface

// File: rtl/tx_pcs_encoder.sv
// 10GBASE-R transmit encoder: XGMII word to 64b/66b block with the
// TX_INIT/C/D/T/E state machine and one-cycle registered latency.
module tx_pcs_encoder (
    input  logic              i_clk,
    input  logic              i_reset,
    tx_pcs_encoder_if.slave   bus
);
    typedef enum logic [2:0] {
        TX_INIT,
        TX_C,
        TX_D,
        TX_T,
        TX_E
    } tx_state_e;

    typedef enum logic [2:0] {
        W_D,
        W_S,
        W_C,
        W_T,
        W_E
    } word_e;

    localparam logic [1:0]  HDR_DATA = 2'b10;
    localparam logic [1:0]  HDR_CTRL = 2'b01;
    localparam logic [63:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E};
    localparam logic [63:0] RST_BLK  = 64'h000000000000001E;

    function automatic logic [6:0] ctl_code(input logic [7:0] ch);
        return (ch == 8'h07) ? 7'h00 : 7'h1E;
    endfunction

    function automatic logic [7:0] t_type(input logic [2:0] k);
        logic [7:0] t;
        t = 8'h87;
        case (k)
            3'd0: t = 8'h87;
            3'd1: t = 8'h99;
            3'd2: t = 8'hAA;
            3'd3: t = 8'hB4;
            3'd4: t = 8'hCC;
            3'd5: t = 8'hD2;
            3'd6: t = 8'hE1;
            3'd7: t = 8'hFF;
            default: t = 8'h87;
        endcase
        return t;
    endfunction

    tx_state_e   state_q, state_d, state_nxt;
    logic [1:0]  header_q, header_d;
    logic [63:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic [63:0] txd;
    logic [7:0]  txc;
    logic [7:0]  ctl_ok;
    logic [7:0]  t_ok;
    logic [2:0]  t_k;
    word_e       wtype;
    logic [1:0]  enc_hdr;
    logic [63:0] enc_data;

    assign txd = bus.xgmii_txd;
    assign txc = bus.xgmii_txc;

    assign bus.phy_tx_ready = bus.i_tx_en && !i_reset;
    assign bus.o_header     = header_q;
    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;

    // Terminate in lane k: txc set for k..7 only, idle/error above k.
    always_comb begin
        ctl_ok = '0;
        for (int i = 0; i < 8; i++) begin
            ctl_ok[i] = (txd[8*i +: 8] == 8'h07) ||
                        (txd[8*i +: 8] == 8'hFE);
        end
        t_ok = '0;
        t_k  = '0;
        for (int k = 0; k < 8; k++) begin
            t_ok[k] = (txd[8*k +: 8] == 8'hFD) &&
                      (txc == (8'hFF << k));
            for (int j = k + 1; j < 8; j++) begin
                t_ok[k] = t_ok[k] & ctl_ok[j];
            end
            if (t_ok[k]) begin
                t_k = 3'(k);
            end
        end
    end

    always_comb begin
        wtype = W_E;
        if (txc == 8'h00) begin
            wtype = W_D;
        end else if (txc == 8'h01 && txd[7:0] == 8'hFB) begin
            wtype = W_S;
        end else if (txc == 8'hFF && (&ctl_ok)) begin
            wtype = W_C;
        end else if (|t_ok) begin
            wtype = W_T;
        end
    end

    always_comb begin
        enc_hdr  = HDR_CTRL;
        enc_data = ERR_BLK;
        unique case (wtype)
            W_D: begin
                enc_hdr  = HDR_DATA;
                enc_data = txd;
            end
            W_S: begin
                enc_data = {txd[63:8], 8'h78};
            end
            W_C: begin
                enc_data      = '0;
                enc_data[7:0] = 8'h1E;
                for (int i = 0; i < 8; i++) begin
                    enc_data[7*i+8 +: 7] = ctl_code(txd[8*i +: 8]);
                end
            end
            W_T: begin
                // Data sits right after the type byte, codes sit in the
                // same slots a C block would use; the gap is zero pad.
                enc_data      = '0;
                enc_data[7:0] = t_type(t_k);
                for (int i = 0; i < 7; i++) begin
                    if (3'(i) < t_k) begin
                        enc_data[8*i+8 +: 8] = txd[8*i +: 8];
                    end
                end
                for (int i = 0; i < 8; i++) begin
                    if (3'(i) > t_k) begin
                        enc_data[7*i+8 +: 7] = ctl_code(txd[8*i +: 8]);
                    end
                end
            end
            default: begin
                enc_hdr  = HDR_CTRL;
                enc_data = ERR_BLK;
            end
        endcase
    end

    always_comb begin
        state_nxt = TX_E;
        unique case (state_q)
            TX_INIT, TX_C, TX_T: begin
                if (wtype == W_C) begin
                    state_nxt = TX_C;
                end else if (wtype == W_S) begin
                    state_nxt = TX_D;
                end else begin
                    state_nxt = TX_E;
                end
            end
            TX_D: begin
                if (wtype == W_D) begin
                    state_nxt = TX_D;
                end else if (wtype == W_T) begin
                    state_nxt = TX_T;
                end else begin
                    state_nxt = TX_E;
                end
            end
            TX_E: begin
                unique case (wtype)
                    W_C:     state_nxt = TX_C;
                    W_D:     state_nxt = TX_D;
                    W_T:     state_nxt = TX_T;
                    W_S:     state_nxt = TX_D;
                    default: state_nxt = TX_E;
                endcase
            end
            default: state_nxt = TX_E;
        endcase
    end

    // A paused cycle freezes everything except o_valid.
    always_comb begin
        state_d  = state_q;
        header_d = header_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (bus.i_tx_en) begin
            state_d = state_nxt;
            valid_d = 1'b1;
            if (state_nxt == TX_E) begin
                header_d = HDR_CTRL;
                data_d   = ERR_BLK;
            end else begin
                header_d = enc_hdr;
                data_d   = enc_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= TX_INIT;
            header_q <= HDR_CTRL;
            data_q   <= RST_BLK;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            header_q <= header_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end
endmodule
